// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file writeback arbiter: write modes, widths and the write request record.
package rf_wb_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 1 << REG_W;

  typedef enum logic [1:0] {
    RW_NONE = 2'd0,
    RW_WORD = 2'd1,
    RW_BYTE = 2'd2,
    RW_HALF = 2'd3
  } rw_mode_e;

  // "reg" is a keyword, so the destination field is named dst
  typedef struct packed {
    rw_mode_e          mode;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of WB-stage, mul/div, hazard-unit and register-file signals seen by rf_wb_arbiter.
// RF_WB_BYPASS_EN adds the read-during-write forwarding outputs.
interface rf_wb_arbiter_if;
  import rf_wb_pkg::*;

  logic              A_Valid;
  logic [1:0]        A_Mode;
  logic [REG_W-1:0]  A_Reg;
  logic [DATA_W-1:0] A_Data;
  logic              B_Valid;
  logic              B_Ready;
  logic [1:0]        B_Mode;
  logic [REG_W-1:0]  B_Reg;
  logic [DATA_W-1:0] B_Data;
  logic              Issue_Valid;
  logic [REG_W-1:0]  Issue_Reg;
  logic [REG_W-1:0]  ReadRegister1;
  logic [REG_W-1:0]  ReadRegister2;
  logic              Stall;
  logic              Hold;
  logic [1:0]        RegWrite;
  logic [REG_W-1:0]  WriteRegister;
  logic [DATA_W-1:0] WriteData;
  logic              Err;
`ifdef RF_WB_BYPASS_EN
  logic              FwdValid1;
  logic              FwdValid2;
  logic [DATA_W-1:0] FwdData1;
  logic [DATA_W-1:0] FwdData2;
`endif

  modport master (
    output A_Valid, A_Mode, A_Reg, A_Data,
    output B_Valid, B_Mode, B_Reg, B_Data,
    output Issue_Valid, Issue_Reg, ReadRegister1, ReadRegister2,
    input  B_Ready, Stall, Hold, RegWrite, WriteRegister, WriteData, Err
`ifdef RF_WB_BYPASS_EN
    , input FwdValid1, FwdValid2, FwdData1, FwdData2
`endif
  );

  modport slave (
    input  A_Valid, A_Mode, A_Reg, A_Data,
    input  B_Valid, B_Mode, B_Reg, B_Data,
    input  Issue_Valid, Issue_Reg, ReadRegister1, ReadRegister2,
    output B_Ready, Stall, Hold, RegWrite, WriteRegister, WriteData, Err
`ifdef RF_WB_BYPASS_EN
    , output FwdValid1, FwdValid2, FwdData1, FwdData2
`endif
  );

endinterface

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of wb_req_t; registered push, no fall-through, simultaneous push/pop allowed when full.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t pop_data,
  output logic    full,
  output logic    empty
);

  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

  wb_req_t       mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign rd_en    = pop && !empty;
  assign wr_en    = push && (!full || rd_en);
  assign pop_data = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register-file write port between the WB stage (A) and buffered mul/div results (B),
// tracks busy destinations and raises Stall/Hold. RF_WB_BYPASS_EN enables read-during-write forwarding.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic            Clk,
  input logic            Reset_n,
  rf_wb_arbiter_if.slave bus
);

  localparam int unsigned         STARVE_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_LIMIT - 1);

  wb_req_t             a_req, b_req, head;
  wb_req_t             out_q, out_d;
  logic                a_win, b_push, pop;
  logic                fifo_full, fifo_empty;
  logic                issue_set;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                hold_q, hold_d;
  logic                err_q, err_d;
  logic                rdw1, rdw2;

  assign a_req = '{mode: rw_mode_e'(bus.A_Mode), dst: bus.A_Reg, data: bus.A_Data};
  assign b_req = '{mode: rw_mode_e'(bus.B_Mode), dst: bus.B_Reg, data: bus.B_Data};

  // Writes to r0 or with mode none are dropped up front so they never occupy the port or the FIFO
  assign a_win     = bus.A_Valid && (a_req.mode != RW_NONE) && (a_req.dst != '0);
  assign b_push    = bus.B_Valid && !fifo_full && (b_req.mode != RW_NONE) && (b_req.dst != '0);
  assign pop       = !a_win && !fifo_empty;
  assign issue_set = bus.Issue_Valid && (bus.Issue_Reg != '0);

  rf_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .push     (b_push),
    .push_data(b_req),
    .pop      (pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    out_d    = '0;
    busy_d   = busy_q;
    starve_d = starve_q;
    hold_d   = 1'b0;
    err_d    = err_q;

    if (a_win)    out_d = a_req;
    else if (pop) out_d = head;

    // Clear before set so an issue to the register being committed keeps it busy
    if (pop)       busy_d[head.dst]      = 1'b0;
    if (issue_set) busy_d[bus.Issue_Reg] = 1'b1;
    busy_d[0] = 1'b0;

    if (issue_set && busy_q[bus.Issue_Reg]) err_d = 1'b1;
    if (a_win && busy_q[bus.A_Reg])         err_d = 1'b1;
    if (bus.A_Valid && hold_q)              err_d = 1'b1;

    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (a_win) begin
      if (starve_q == STARVE_LAST) begin
        hold_d   = 1'b1;
        starve_d = '0;
      end else begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_q    <= '0;
      busy_q   <= '0;
      starve_q <= '0;
      hold_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      out_q    <= out_d;
      busy_q   <= busy_d;
      starve_q <= starve_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
    end
  end

  assign bus.B_Ready       = !fifo_full;
  assign bus.Hold          = hold_q;
  assign bus.Err           = err_q;
  assign bus.RegWrite      = out_q.mode;
  assign bus.WriteRegister = out_q.dst;
  assign bus.WriteData     = out_q.data;

  assign rdw1 = (out_q.mode != RW_NONE) && (bus.ReadRegister1 == out_q.dst) && (bus.ReadRegister1 != '0);
  assign rdw2 = (out_q.mode != RW_NONE) && (bus.ReadRegister2 == out_q.dst) && (bus.ReadRegister2 != '0);

`ifdef RF_WB_BYPASS_EN
  assign bus.Stall     = busy_q[bus.ReadRegister1] | busy_q[bus.ReadRegister2];
  assign bus.FwdValid1 = rdw1;
  assign bus.FwdValid2 = rdw2;
  assign bus.FwdData1  = out_q.data;
  assign bus.FwdData2  = out_q.data;
`else
  assign bus.Stall = busy_q[bus.ReadRegister1] | busy_q[bus.ReadRegister2] | rdw1 | rdw2;
`endif

endmodule
